// File: rtl/jedec_p.sv
`default_nettype none
// ============================================================================
//  Module      : jedec_p (package)
//  Description : Shared types and constants for the eMMC command responder:
//                response type enum, controller state enum, frame length,
//                CRC7 polynomial, R3 index field and a one-step CRC7 helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package jedec_p;

    localparam int          CMD_FRAME_LEN = 48;
    localparam logic [6:0]  CRC7_POLY     = 7'h09;   // x^7 + x^3 + 1
    localparam logic [5:0]  R3_IDX        = 6'h3F;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_R1   = 2'd1,
        RSP_R3   = 2'd2
    } rsp_type_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RX       = 3'd1,
        CHECK    = 3'd2,
        WAIT_RSP = 3'd3,
        NCR_GAP  = 3'd4,
        TX       = 3'd5
    } state_t;

    // One bit of the MSB-first serial CRC7 update.
    function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc7_serial.sv
`default_nettype none
// ============================================================================
//  Module      : crc7_serial
//  Description : Bit-serial CRC7 (x^7+x^3+1) accumulator, MSB first.
//  Ports       : clk    - clock
//                rst    - asynchronous active-high reset
//                i_clr  - synchronous clear (wins over i_en)
//                i_en   - accumulate i_bit this cycle
//                i_bit  - serial data bit
//                o_crc  - current CRC7 remainder
//  Revision    : 1.0 - initial release
// ============================================================================
module crc7_serial
    import jedec_p::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [6:0] o_crc
);

    logic [6:0] r_crc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc <= 7'h00;
        end else if (i_clr) begin
            r_crc <= 7'h00;
        end else if (i_en) begin
            r_crc <= crc7_next(r_crc, i_bit);
        end
    end

    assign o_crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/emmc_cmd_responder.sv
`default_nettype none
// ============================================================================
//  Module      : emmc_cmd_responder
//  Description : Device-side eMMC CMD-line engine. Receives 48-bit host
//                commands, validates framing (and optionally CRC7), hands the
//                index/argument to the user, then serialises an R1 or R3
//                response after the NCR gap.
//  Ports       : clk_i, arst_i             - clock, async active-high reset
//                emmc_cmd_i/_o/_oe_o       - CMD pad in / drive / enable
//                cmd_valid_o, cmd_idx_o,
//                cmd_arg_o                 - accepted command to user
//                rsp_valid_i, rsp_type_i,
//                rsp_arg_i                 - response request from user
//                crc_err_o, frame_err_o    - error pulses
//                busy_o                    - high whenever not IDLE
//  Config      : EMMC_RSP_CRC_CHECK_EN - when defined, commands with a bad
//                CRC7 are dropped with a crc_err_o pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module emmc_cmd_responder
    import jedec_p::*;
#(
    parameter int NCR         = 2,
    parameter int RSP_TIMEOUT = 64
)(
    input  logic        clk_i,
    input  logic        arst_i,
    input  logic        emmc_cmd_i,
    output logic        emmc_cmd_o,
    output logic        emmc_cmd_oe_o,
    output logic        cmd_valid_o,
    output logic [5:0]  cmd_idx_o,
    output logic [31:0] cmd_arg_o,
    input  logic        rsp_valid_i,
    input  rsp_type_t   rsp_type_i,
    input  logic [31:0] rsp_arg_i,
    output logic        crc_err_o,
    output logic        frame_err_o,
    output logic        busy_o
);

    localparam int             TW          = $clog2(RSP_TIMEOUT + 1);
    localparam logic [5:0]     c_last_bit  = 6'(CMD_FRAME_LEN - 1);
    localparam logic [TW-1:0]  c_tmo_last  = TW'(RSP_TIMEOUT - 1);
    localparam logic [31:0]    c_ncr       = NCR;

    state_t        r_state, w_next;
    logic [5:0]    r_bit_cnt;
    logic [46:0]   r_rx_shift;   // frame bits 1..47, bit 1 at the top
    logic [TW-1:0] r_since;      // clock edges since the end-bit sample
    logic [39:0]   r_tx_data;    // response bits 0..39
    logic          r_rsp_r3;
    logic [5:0]    r_cmd_idx;
    logic [31:0]   r_cmd_arg;
    logic          r_cmd_valid, r_crc_err, r_frame_err;

    logic [6:0]    w_crc;
    logic          w_crc_clr, w_crc_en, w_crc_bit;
    logic          w_tx_bit, w_frame_bad, w_crc_bad, w_gap_done;
    logic [2:0]    w_crc_idx;

    crc7_serial u_crc7 (
        .clk   (clk_i),
        .rst   (arst_i),
        .i_clr (w_crc_clr),
        .i_en  (w_crc_en),
        .i_bit (w_crc_bit),
        .o_crc (w_crc)
    );

    assign w_frame_bad = !r_rx_shift[46] || !r_rx_shift[0];
`ifdef EMMC_RSP_CRC_CHECK_EN
    assign w_crc_bad   = (r_rx_shift[7:1] != w_crc);
`else
    assign w_crc_bad   = 1'b0;
`endif

    // True when driving the start bit on the next edge lands at or beyond NCR.
    assign w_gap_done = (32'(r_since) + 32'd1) >= c_ncr;

    assign w_crc_idx = 3'(6'd46 - r_bit_cnt);

    always_comb begin
        w_tx_bit = 1'b1;
        if (r_bit_cnt < 6'd40) begin
            w_tx_bit = r_tx_data[6'd39 - r_bit_cnt];
        end else if (r_bit_cnt < c_last_bit) begin
            w_tx_bit = r_rsp_r3 ? 1'b1 : w_crc[w_crc_idx];
        end
    end

    // The start bit is 0, so a cleared CRC already equals the CRC after the
    // start bit; keeping the accumulator clear in IDLE covers bit 0 of RX.
    assign w_crc_clr = (r_state == IDLE) || (r_state == CHECK) ||
                       (r_state == WAIT_RSP) || (r_state == NCR_GAP);
    assign w_crc_en  = ((r_state == RX) && (r_bit_cnt <= 6'd39)) ||
                       ((r_state == TX) && (r_bit_cnt <  6'd40));
    assign w_crc_bit = (r_state == TX) ? w_tx_bit : emmc_cmd_i;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (!emmc_cmd_i) w_next = RX;
            RX:       if (r_bit_cnt == c_last_bit) w_next = CHECK;
            CHECK:    w_next = (w_frame_bad || w_crc_bad) ? IDLE : WAIT_RSP;
            WAIT_RSP: begin
                if (rsp_valid_i) begin
                    if (rsp_type_i == RSP_NONE) w_next = IDLE;
                    else if (w_gap_done)        w_next = TX;
                    else                        w_next = NCR_GAP;
                end else if (r_since == c_tmo_last) begin
                    w_next = IDLE;
                end
            end
            NCR_GAP:  if (w_gap_done) w_next = TX;
            TX:       if (r_bit_cnt == c_last_bit) w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state     <= IDLE;
            r_bit_cnt   <= 6'd0;
            r_rx_shift  <= '0;
            r_since     <= '0;
            r_tx_data   <= '0;
            r_rsp_r3    <= 1'b0;
            r_cmd_idx   <= 6'd0;
            r_cmd_arg   <= 32'd0;
            r_cmd_valid <= 1'b0;
            r_crc_err   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cmd_valid <= 1'b0;
            r_crc_err   <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_state != RX && r_state != IDLE && r_since != '1) begin
                r_since <= r_since + TW'(1);
            end
            case (r_state)
                IDLE: r_bit_cnt <= 6'd1;
                RX: begin
                    r_rx_shift <= {r_rx_shift[45:0], emmc_cmd_i};
                    r_since    <= '0;
                    if (r_bit_cnt != c_last_bit) r_bit_cnt <= r_bit_cnt + 6'd1;
                end
                CHECK: begin
                    if (w_frame_bad) begin
                        r_frame_err <= 1'b1;
                    end else if (w_crc_bad) begin
                        r_crc_err <= 1'b1;
                    end else begin
                        r_cmd_valid <= 1'b1;
                        r_cmd_idx   <= r_rx_shift[45:40];
                        r_cmd_arg   <= r_rx_shift[39:8];
                    end
                end
                WAIT_RSP: begin
                    if (rsp_valid_i) begin
                        r_rsp_r3  <= (rsp_type_i == RSP_R3);
                        r_tx_data <= {2'b00, (rsp_type_i == RSP_R3) ? R3_IDX : r_cmd_idx,
                                      rsp_arg_i};
                        r_bit_cnt <= 6'd0;
                    end
                end
                TX: if (r_bit_cnt != c_last_bit) r_bit_cnt <= r_bit_cnt + 6'd1;
                default: ;
            endcase
        end
    end

    assign emmc_cmd_oe_o = (r_state == TX);
    assign emmc_cmd_o    = (r_state == TX) ? w_tx_bit : 1'b1;
    assign cmd_valid_o   = r_cmd_valid;
    assign cmd_idx_o     = r_cmd_idx;
    assign cmd_arg_o     = r_cmd_arg;
    assign crc_err_o     = r_crc_err;
    assign frame_err_o   = r_frame_err;
    assign busy_o        = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_emmc_cmd_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_emmc_cmd_responder
//  Description : Self-checking bench for emmc_cmd_responder. Expected
//                commands, error pulses and response frames are queued when
//                stimulus is driven and compared by a negedge monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_emmc_cmd_responder;
    import jedec_p::*;

    localparam int NCR         = 2;
    localparam int RSP_TIMEOUT = 64;

    logic        clk_i = 1'b0;
    logic        arst_i = 1'b1;
    logic        emmc_cmd_i = 1'b1;
    logic        emmc_cmd_o, emmc_cmd_oe_o, cmd_valid_o;
    logic [5:0]  cmd_idx_o;
    logic [31:0] cmd_arg_o;
    logic        rsp_valid_i = 1'b0;
    rsp_type_t   rsp_type_i = RSP_NONE;
    logic [31:0] rsp_arg_i = 32'd0;
    logic        crc_err_o, frame_err_o, busy_o;

    emmc_cmd_responder #(.NCR(NCR), .RSP_TIMEOUT(RSP_TIMEOUT)) dut (
        .clk_i         (clk_i),
        .arst_i        (arst_i),
        .emmc_cmd_i    (emmc_cmd_i),
        .emmc_cmd_o    (emmc_cmd_o),
        .emmc_cmd_oe_o (emmc_cmd_oe_o),
        .cmd_valid_o   (cmd_valid_o),
        .cmd_idx_o     (cmd_idx_o),
        .cmd_arg_o     (cmd_arg_o),
        .rsp_valid_i   (rsp_valid_i),
        .rsp_type_i    (rsp_type_i),
        .rsp_arg_i     (rsp_arg_i),
        .crc_err_o     (crc_err_o),
        .frame_err_o   (frame_err_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference CRC7, x^7+x^3+1, MSB first.
    function automatic logic [6:0] ref_crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b01, idx, arg, ref_crc7({2'b01, idx, arg}), 1'b1};
    endfunction

    function automatic logic [47:0] mk_r1(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b00, idx, arg, ref_crc7({2'b00, idx, arg}), 1'b1};
    endfunction

    // Scoreboard queues
    logic [37:0] exp_cmd_q[$];
    int          exp_err_q[$];     // 1 = crc error, 2 = frame error
    logic [47:0] exp_rsp_q[$];
    int          exp_start_q[$];

    int          oe_cnt = 0;
    int          start_cyc = 0;
    logic [47:0] rsp_bits = '0;
    logic [37:0] mon_cmd;
    int          last_end = 0;

    always @(negedge clk_i) begin
        if (arst_i) begin
            oe_cnt = 0;
        end else begin
            if (cmd_valid_o) begin
                if (exp_cmd_q.size() == 0) check_eq("cmd_unexpected", 1, 0);
                else begin
                    mon_cmd = exp_cmd_q.pop_front();
                    check_eq("cmd_idx", cmd_idx_o, mon_cmd[37:32]);
                    check_eq("cmd_arg", cmd_arg_o, mon_cmd[31:0]);
                end
            end
            if (crc_err_o) begin
                if (exp_err_q.size() == 0) check_eq("crc_err_unexpected", 1, 0);
                else check_eq("err_kind_crc", exp_err_q.pop_front(), 1);
            end
            if (frame_err_o) begin
                if (exp_err_q.size() == 0) check_eq("frame_err_unexpected", 1, 0);
                else check_eq("err_kind_frame", exp_err_q.pop_front(), 2);
            end
            if (emmc_cmd_oe_o) begin
                if (oe_cnt == 0) start_cyc = cyc;
                rsp_bits = {rsp_bits[46:0], emmc_cmd_o};
                oe_cnt++;
            end else if (oe_cnt != 0) begin
                if (exp_rsp_q.size() == 0) check_eq("rsp_unexpected", 1, 0);
                else begin
                    check_eq("rsp_bits", rsp_bits, exp_rsp_q.pop_front());
                    check_eq("rsp_oe_len", oe_cnt, 48);
                    check_eq("rsp_start_cyc", start_cyc, exp_start_q.pop_front());
                end
                oe_cnt = 0;
            end
        end
    end

    task automatic send_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            @(negedge clk_i);
            emmc_cmd_i = f[i];
        end
        last_end = cyc + 1;
        @(negedge clk_i);
        emmc_cmd_i = 1'b1;
    endtask

    task automatic respond(input rsp_type_t t, input logic [31:0] arg, input logic [5:0] idx,
                           input int dly, input bit push);
        int st;
        for (int i = 0; i < 8 && !cmd_valid_o; i++) @(negedge clk_i);
        if (!cmd_valid_o) begin
            check_eq("cmd_valid_wait", 0, 1);
            return;
        end
        repeat (dly) @(negedge clk_i);
        if (push && t != RSP_NONE) begin
            exp_rsp_q.push_back((t == RSP_R3) ? {2'b00, 6'h3F, arg, 7'h7F, 1'b1} : mk_r1(idx, arg));
            st = (last_end + NCR > cyc + 1) ? last_end + NCR : cyc + 1;
            exp_start_q.push_back(st);
        end
        rsp_valid_i = 1'b1;
        rsp_type_i  = t;
        rsp_arg_i   = arg;
        @(negedge clk_i);
        rsp_valid_i = 1'b0;
        rsp_type_i  = RSP_NONE;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy_o; i++) @(negedge clk_i);
        if (busy_o) check_eq("idle_wait", busy_o, 0);
        repeat (2) @(negedge clk_i);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] f;

        // Reset state
        repeat (3) @(negedge clk_i);
        check_eq("rst_oe", emmc_cmd_oe_o, 0);
        check_eq("rst_cmd_o", emmc_cmd_o, 1);
        check_eq("rst_cmd_valid", cmd_valid_o, 0);
        check_eq("rst_crc_err", crc_err_o, 0);
        check_eq("rst_frame_err", frame_err_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_idx", cmd_idx_o, 0);
        check_eq("rst_arg", cmd_arg_o, 0);
        arst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // CMD0 with no response
        exp_cmd_q.push_back({6'd0, 32'd0});
        send_frame(48'h40_00000000_95);
        respond(RSP_NONE, 32'd0, 6'd0, 0, 1'b0);
        wait_idle();

        // CMD17 with an immediate R1
        exp_cmd_q.push_back({6'd17, 32'd0});
        send_frame(48'h51_00000000_55);
        respond(RSP_R1, 32'h0000_0900, 6'd17, 0, 1'b1);
        wait_idle();

        // CMD1 with R3
        exp_cmd_q.push_back({6'd1, 32'h40FF_8000});
        send_frame(mk_cmd(6'd1, 32'h40FF_8000));
        respond(RSP_R3, 32'hC0FF_8080, 6'd1, 0, 1'b1);
        wait_idle();

        // CMD13 with a late R1, start bit follows the response request
        exp_cmd_q.push_back({6'd13, 32'h0001_0000});
        send_frame(mk_cmd(6'd13, 32'h0001_0000));
        respond(RSP_R1, 32'hDEAD_BEEF, 6'd13, 5, 1'b1);
        wait_idle();

        // CMD8 with one CRC bit flipped
        f = 48'h48_000001AA_87 ^ 48'h2;
`ifdef EMMC_RSP_CRC_CHECK_EN
        exp_err_q.push_back(1);
        send_frame(f);
        wait_idle();
`else
        exp_cmd_q.push_back({6'd8, 32'h0000_01AA});
        send_frame(f);
        respond(RSP_NONE, 32'd0, 6'd8, 0, 1'b0);
        wait_idle();
`endif

        // Framing errors: transmission bit 0, then end bit 0
        exp_err_q.push_back(2);
        send_frame(48'h00_00000000_01);
        wait_idle();
        exp_err_q.push_back(2);
        send_frame(48'h40_00000000_94);
        wait_idle();

        // Timeout: no response, host toggles CMD during the wait
        exp_cmd_q.push_back({6'd17, 32'd0});
        send_frame(48'h51_00000000_55);
        while (cyc < last_end + 10) @(negedge clk_i);
        emmc_cmd_i = 1'b0;
        repeat (3) @(negedge clk_i);
        emmc_cmd_i = 1'b1;
        while (cyc < last_end + RSP_TIMEOUT - 1) @(negedge clk_i);
        check_eq("tmo_busy_before", busy_o, 1);
        @(negedge clk_i);
        check_eq("tmo_busy_after", busy_o, 0);
        exp_cmd_q.push_back({6'd8, 32'h0000_01AA});
        send_frame(48'h48_000001AA_87);
        respond(RSP_R1, 32'h0000_01AA, 6'd8, 0, 1'b1);
        wait_idle();

        // Reset during TX bit 20
        exp_cmd_q.push_back({6'd17, 32'd0});
        send_frame(48'h51_00000000_55);
        respond(RSP_R1, 32'h0000_0900, 6'd17, 0, 1'b0);
        for (int i = 0; i < 8 && !emmc_cmd_oe_o; i++) @(negedge clk_i);
        check_eq("abort_oe_rise", emmc_cmd_oe_o, 1);
        repeat (20) @(negedge clk_i);
        #1 arst_i = 1'b1;
        #1;
        check_eq("abort_oe_low", emmc_cmd_oe_o, 0);
        check_eq("abort_busy", busy_o, 0);
        check_eq("abort_cmd_o", emmc_cmd_o, 1);
        repeat (2) @(negedge clk_i);
        arst_i = 1'b0;
        @(negedge clk_i);
        exp_cmd_q.push_back({6'd0, 32'd0});
        send_frame(48'h40_00000000_95);
        respond(RSP_NONE, 32'd0, 6'd0, 0, 1'b0);
        wait_idle();

        check_eq("cmd_q_empty", exp_cmd_q.size(), 0);
        check_eq("err_q_empty", exp_err_q.size(), 0);
        check_eq("rsp_q_empty", exp_rsp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
